// File: rtl/snake_pkg.sv
// Shared encodings and screen geometry for the snake game controller, head datapath and renderer.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PLAY  = 2'b01,
    ST_PAUSE = 2'b10,
    ST_OVER  = 2'b11
  } state_t;

  localparam int SCREEN_W  = 640;
  localparam int SCREEN_H  = 480;
  localparam int BORDER_PX = 20;
  localparam int HEAD_PX   = 20;
  localparam int STEP_PX   = 10;

  localparam int DELAY_W = 24;

  // Opposite directions share bit 1 and differ only in bit 0.
  function automatic logic is_reverse(dir_t a, dir_t b);
    return (a[1] == b[1]) && (a[0] != b[0]);
  endfunction

endpackage

// File: rtl/snake_move_timer.sv
// Programmable move tick: counts 0..period-1 while enabled; the period is latched on clear and on every wrap.
module snake_move_timer
  import snake_pkg::*;
(
  input  logic               clk,
  input  logic               srst,
  input  logic               enable,
  input  logic               clear,
  input  logic [DELAY_W-1:0] delay,
  output logic               tick
);

  logic [DELAY_W-1:0] count_reg;
  logic [DELAY_W-1:0] period_reg;

  assign tick = enable && !clear && (count_reg == period_reg - DELAY_W'(1));

  always_ff @(posedge clk) begin
    if (srst) begin
      count_reg  <= '0;
      period_reg <= '0;
    end else if (clear || tick) begin
      count_reg  <= '0;
      period_reg <= delay;
    end else if (enable) begin
      count_reg <= count_reg + DELAY_W'(1);
    end
  end

endmodule

// File: rtl/snake_game_ctrl.sv
// Top-level snake game sequencer: game FSM, move tick, direction commit, wall prediction, score/length/speed.
module snake_game_ctrl
  import snake_pkg::*;
#(
  parameter int SCREEN_WIDTH     = SCREEN_W,
  parameter int SCREEN_HEIGHT    = SCREEN_H,
  parameter int BORDER_THICKNESS = BORDER_PX,
  parameter int SNAKEHEAD_SIZE   = HEAD_PX,
  parameter int MOVE_STEP        = STEP_PX,
  parameter int MOVE_DELAY       = 5_000_000,
  parameter int MIN_DELAY        = 1_000_000,
  parameter int SPEED_STEP       = 250_000,
  parameter int INIT_LEN         = 3,
  parameter int MAX_LEN          = 64
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [3:0]  KEY,
  input  logic        start,
  input  logic        pause,
  input  logic [11:0] head_x,
  input  logic [11:0] head_y,
  input  logic        food_hit,
  input  logic        self_hit,
  output logic        move_en,
  output logic        restart,
  output logic [1:0]  dir,
  output logic [1:0]  state,
  output logic        game_over,
  output logic        grow,
  output logic [15:0] score,
  output logic [7:0]  snake_len
);

  localparam logic [DELAY_W-1:0] DELAY_INIT = DELAY_W'(MOVE_DELAY);
  localparam logic [DELAY_W-1:0] DELAY_MIN  = DELAY_W'(MIN_DELAY);
  localparam logic [DELAY_W-1:0] DELAY_STEP = DELAY_W'(SPEED_STEP);
  localparam logic [7:0]         LEN_INIT   = 8'(INIT_LEN);
  localparam logic [7:0]         LEN_MAX    = 8'(MAX_LEN);

  // Legal top-left range of the head; "x + size > width - border" folds into "x > x_hi".
  localparam logic signed [12:0] X_LO = 13'(BORDER_THICKNESS);
  localparam logic signed [12:0] X_HI = 13'(SCREEN_WIDTH - BORDER_THICKNESS - SNAKEHEAD_SIZE);
  localparam logic signed [12:0] Y_LO = 13'(BORDER_THICKNESS);
  localparam logic signed [12:0] Y_HI = 13'(SCREEN_HEIGHT - BORDER_THICKNESS - SNAKEHEAD_SIZE);
  localparam logic signed [12:0] STEP = 13'(MOVE_STEP);

  state_t             state_reg;
  dir_t               dir_reg;
  dir_t               pending_reg;
  logic [15:0]        score_reg;
  logic [7:0]         len_reg;
  logic [DELAY_W-1:0] delay_reg;
  logic               move_en_reg;
  logic               restart_reg;
  logic               grow_reg;
  logic               food_prev_reg;
  logic               start_armed_reg;

  logic               tick;
  logic               wall_hit;
  logic               food_edge;
  logic               start_game;
  logic               key_valid;
  dir_t               key_dir;
  dir_t               dir_ref;
  logic signed [12:0] next_x;
  logic signed [12:0] next_y;

  snake_move_timer u_timer (
    .clk    (CLOCK_50),
    .srst   (reset),
    .enable (state_reg == ST_PLAY),
    .clear  ((state_reg == ST_IDLE) || restart_reg),
    .delay  (delay_reg),
    .tick   (tick)
  );

  always_comb begin
    key_valid = 1'b1;
    key_dir   = DIR_RIGHT;
    if (!KEY[2])      key_dir = DIR_UP;
    else if (!KEY[1]) key_dir = DIR_DOWN;
    else if (!KEY[3]) key_dir = DIR_LEFT;
    else if (!KEY[0]) key_dir = DIR_RIGHT;
    else              key_valid = 1'b0;
  end

  // On a tick the pending dir becomes committed this cycle, so reversal is judged against it.
  assign dir_ref = tick ? pending_reg : dir_reg;

  always_comb begin
    next_x = $signed({1'b0, head_x});
    next_y = $signed({1'b0, head_y});
    case (pending_reg)
      DIR_UP:    next_y = next_y - STEP;
      DIR_DOWN:  next_y = next_y + STEP;
      DIR_LEFT:  next_x = next_x - STEP;
      DIR_RIGHT: next_x = next_x + STEP;
    endcase
  end

  assign wall_hit   = (next_x < X_LO) || (next_x > X_HI) || (next_y < Y_LO) || (next_y > Y_HI);
  assign food_edge  = food_hit && !food_prev_reg;
  assign start_game = start && ((state_reg == ST_IDLE) || (state_reg == ST_OVER && start_armed_reg));

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      dir_reg         <= DIR_RIGHT;
      pending_reg     <= DIR_RIGHT;
      score_reg       <= '0;
      len_reg         <= LEN_INIT;
      delay_reg       <= DELAY_INIT;
      move_en_reg     <= 1'b0;
      restart_reg     <= 1'b0;
      grow_reg        <= 1'b0;
      food_prev_reg   <= 1'b0;
      start_armed_reg <= 1'b0;
    end else begin
      move_en_reg   <= 1'b0;
      restart_reg   <= 1'b0;
      grow_reg      <= 1'b0;
      food_prev_reg <= food_hit;

      if (start_game) begin
        state_reg   <= ST_PLAY;
        restart_reg <= 1'b1;
        dir_reg     <= DIR_RIGHT;
        pending_reg <= DIR_RIGHT;
        score_reg   <= '0;
        len_reg     <= LEN_INIT;
        delay_reg   <= DELAY_INIT;
      end

      case (state_reg)
        ST_PLAY: begin
          if (key_valid && !is_reverse(key_dir, dir_ref))
            pending_reg <= key_dir;
          if (self_hit || (tick && wall_hit)) begin
            state_reg       <= ST_OVER;
            start_armed_reg <= 1'b0;
          end else begin
            if (food_edge) begin
              grow_reg <= 1'b1;
              if (score_reg != 16'hFFFF) score_reg <= score_reg + 16'd1;
              if (len_reg < LEN_MAX)     len_reg   <= len_reg + 8'd1;
              if (delay_reg >= DELAY_MIN + DELAY_STEP) delay_reg <= delay_reg - DELAY_STEP;
              else                                     delay_reg <= DELAY_MIN;
            end
            if (tick) begin
              move_en_reg <= 1'b1;
              dir_reg     <= pending_reg;
            end
            if (pause) state_reg <= ST_PAUSE;
          end
        end
        ST_PAUSE: if (!pause) state_reg <= ST_PLAY;
        ST_OVER:  if (!start) start_armed_reg <= 1'b1;
        default: ;
      endcase
    end
  end

  assign move_en   = move_en_reg;
  assign restart   = restart_reg;
  assign dir       = dir_reg;
  assign state     = state_reg;
  assign game_over = (state_reg == ST_OVER);
  assign grow      = grow_reg;
  assign score     = score_reg;
  assign snake_len = len_reg;

endmodule

// File: doc/snake_game_ctrl.md
# snake_game_ctrl

Game-sequencing controller for the snake datapath. It runs the top-level game state machine (idle, play, pause, over) and generates the autonomous movement tick. It owns the committed direction, with reversal rejection, and predicts wall collisions before each step. It also tracks score and length and shortens the move interval as food is eaten. It sits between the board inputs (KEY, switches) and the snake head/body datapath, which moves only on `move_en`.

## Interface
- `SCREEN_WIDTH`, 640: visible width in pixels.
- `SCREEN_HEIGHT`, 480: visible height in pixels.
- `BORDER_THICKNESS`, 20: wall thickness in pixels.
- `SNAKEHEAD_SIZE`, 20: head square edge in pixels.
- `MOVE_STEP`, 10: pixels per move.
- `MOVE_DELAY`, 5_000_000: initial clocks between moves.
- `MIN_DELAY`, 1_000_000: floor of the move interval.
- `SPEED_STEP`, 250_000: interval reduction per food eaten.
- `INIT_LEN`, 3: length after restart.
- `MAX_LEN`, 64: length saturation value.
- `CLOCK_50  in  1`: system clock; all logic on the rising edge.
- `reset  in  1`: synchronous, active-high.
- `KEY  in  4`: active-low direction keys. [2] up, [1] down, [3] left, [0] right; priority in that order.
- `start  in  1`: level. Starts the game from IDLE; restarts it from OVER.
- `pause  in  1`: level. 1 requests pause while playing.
- `head_x`, `head_y  in  12 each`: current head top-left position from the datapath.
- `food_hit  in  1`: head overlaps food. Sampled every cycle in PLAY.
- `self_hit  in  1`: head overlaps body. Sampled every cycle in PLAY.
- `move_en  out  1`: one-cycle pulse; the datapath advances one step in `dir`.
- `restart  out  1`: one-cycle pulse; the datapath recenters and clears the body.
- `dir  out  2`: committed direction. 00 up, 01 down, 10 left, 11 right.
- `state  out  2`: 00 IDLE, 01 PLAY, 10 PAUSE, 11 OVER.
- `game_over  out  1`: equals (state == OVER).
- `grow  out  1`: one-cycle pulse on each accepted food.
- `score  out  16`: food count; saturates at 16'hFFFF.
- `snake_len  out  8`: current length.

## Operation
- **Reset values:** state=IDLE, dir=11, pending dir=11, score=0, snake_len=INIT_LEN, current delay=MOVE_DELAY, tick counter=0, all pulses 0.
- **IDLE:**
  - start=1 → PLAY; `restart` pulses in the same transition cycle.
  - Counter, score, length and delay are re-initialised.
- **PLAY:**
  - Priority order: self_hit → OVER. Wall prediction at tick → OVER. pause=1 → PAUSE.
  - Collision beats food in the same cycle: food is ignored and there is no grow.
- **PAUSE:**
  - The counter holds and keys are ignored.
  - pause=0 → PLAY, resuming from the held count.
- **OVER:**
  - Everything is frozen.
  - start=1 → PLAY with full re-initialisation and a `restart` pulse.
  - start must be seen 0 at least once in OVER before it is accepted; a held start does not auto-restart.
- **Direction:**
  - In PLAY, each cycle the highest-priority pressed key loads the pending dir.
  - A key that would reverse the committed dir (up↔down, left↔right) is dropped.
  - The committed dir takes the pending value only on a `move_en` cycle, so at most one turn per step.
- **Wall prediction** is evaluated when the counter reaches the current delay minus 1, using head_x/head_y and the pending dir:
  - Up: next y = head_y − MOVE_STEP.
  - Down: next y = head_y + MOVE_STEP.
  - Left: next x = head_x − MOVE_STEP.
  - Right: next x = head_x + MOVE_STEP.
  - Collision if next x < BORDER_THICKNESS, next x + SNAKEHEAD_SIZE > SCREEN_WIDTH − BORDER_THICKNESS, or the same tests on y against SCREEN_HEIGHT.
  - Arithmetic is 13-bit signed, so an underflow counts as a collision.
  - Collision → OVER and no `move_en`; otherwise `move_en` pulses.
- **Food**, on a food_hit rising edge in PLAY only:
  - score increments (saturating) and snake_len increments (saturating at MAX_LEN).
  - `grow` pulses.
  - Current delay = max(delay − SPEED_STEP, MIN_DELAY).

## Timing
- The counter runs 0 … delay−1 in PLAY only.
- The tick cycle is registered: `move_en` and the committed-dir update occur one cycle after the counter hits delay−1; the counter returns to 0 in that same cycle.
- A changed delay takes effect from the next counter wrap.
- The state change to OVER/PAUSE is registered, one cycle after the causing input.
- `restart` is high for exactly the first PLAY cycle after IDLE/OVER.
- reset asserted mid-game takes priority over every input in that cycle.

## Structure
- Shared package `snake_pkg` holds:
  - Direction encodings (DIR_UP/DOWN/LEFT/RIGHT).
  - State encodings.
  - Screen and border constants, also used by the snake head and renderer.
- Sub-module `snake_move_timer` is the programmable tick counter: inputs enable, clear and delay; output a tick pulse.

## Test plan
- **Idle then start:** reset, then start=1 → state=01, `restart` for 1 cycle. With MOVE_DELAY=4: first `move_en` 5 cycles after entering PLAY, then every 4 cycles.
- **Reversal and turn rate:** dir=11, press KEY[3] (left) → no change. Press KEY[2] then KEY[1] within one interval → dir=01 at the next `move_en`.
- **Wall prediction:** head_x=600, dir right, SIZE 20, border 20 → next x=610, 630 > 620 → OVER, no `move_en`, game_over=1.
- **Food and speed-up:** 3 food_hit pulses with MOVE_DELAY=8, SPEED_STEP=2, MIN_DELAY=4:
  - score=3, snake_len=6, 3 grow pulses.
  - Interval 8→6→4→4.
- **Pause:** pause=1 at counter=2 → no `move_en` while paused; after release the tick comes delay−2 cycles later.
- **Simultaneous events and restart:** self_hit together with food_hit → OVER, score unchanged. Held start does not restart; release then press → PLAY, score=0, len=INIT_LEN.
